// File: rtl/sfifo_pkg.sv
// Shared definitions for the level-reporting synchronous FIFO family:
// address-width helper and the reset value of a data word.
package sfifo_pkg;

  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 32'd1) ? $clog2(depth) : 32'd1;
  endfunction

  localparam logic DATA_RST_BIT = 1'b0;

endpackage

// File: rtl/sfifo_lvl_dpram.sv
// Depth x Width dual-port RAM: synchronous write port, registered read port.
// Only the read register is reset; the storage array is not.
module sfifo_lvl_dpram
  import sfifo_pkg::*;
#(
  parameter int unsigned Depth = 512,
  parameter int unsigned Width = 8,
  parameter int unsigned AW    = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             WrEn,
  input  logic [AW-1:0]    WrAddr,
  input  logic [Width-1:0] WrData,
  input  logic             RdEn,
  input  logic [AW-1:0]    RdAddr,
  output logic [Width-1:0] RdData
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rd_data_q;

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (WrEn) begin
      mem_q[WrAddr] <= WrData;
    end
  end

  // Registered read port; holds its value when no read is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= {Width{DATA_RST_BIT}};
    end else if (RdEn) begin
      rd_data_q <= mem_q[RdAddr];
    end
  end

  assign RdData = rd_data_q;

endmodule

// File: rtl/sfifo_lvl.sv
// Single-clock FIFO with fill level, almost-full/almost-empty flags and read-valid strobe.
// Optional sticky overflow/underflow flags are enabled by defining SFIFO_LVL_ERRFLAG_EN.
module sfifo_lvl
  import sfifo_pkg::*;
#(
  parameter int unsigned Depth    = 512,
  parameter int unsigned Width    = 8,
  parameter int unsigned AFThresh = Depth - 4,
  parameter int unsigned AEThresh = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [Width-1:0]       WRData,
  input  logic                   FIFOWrReq,
  input  logic                   FIFORdReq,
  input  logic                   ErrClr,
  output logic [Width-1:0]       RDData,
  output logic                   RDValid,
  output logic                   FIFOFull,
  output logic                   FIFOEmpty,
  output logic                   AlmostFull,
  output logic                   AlmostEmpty,
  output logic [$clog2(Depth):0] Level,
  output logic                   Overflow,
  output logic                   Underflow
);

  localparam int unsigned AW = addr_w(Depth);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(Depth);
  localparam logic [LW-1:0] AF_L    = LW'(AFThresh);
  localparam logic [LW-1:0] AE_L    = LW'(AEThresh);

  logic [LW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          rd_valid_q, rd_valid_d;
  logic          full_s, empty_s;
  logic          wr_acc_s, rd_acc_s;

  assign full_s  = (level_q == DEPTH_L);
  assign empty_s = (level_q == {LW{1'b0}});

  // Acceptance, pointer advance and level bookkeeping.
  always_comb begin
    wr_acc_s   = FIFOWrReq & ~full_s;
    rd_acc_s   = FIFORdReq & ~empty_s;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    rd_valid_d = rd_acc_s;
    if (wr_acc_s) begin
      wr_ptr_d = wr_ptr_q + LW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_acc_s) begin
      rd_ptr_d = rd_ptr_q + LW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_acc_s, rd_acc_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer, level and read-valid state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= {LW{1'b0}};
      rd_ptr_q   <= {LW{1'b0}};
      level_q    <= {LW{1'b0}};
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // The wrap bits are kept for pointer symmetry; fullness comes from the level counter.
  logic unused_ptr_msb_s;
  assign unused_ptr_msb_s = wr_ptr_q[AW] ^ rd_ptr_q[AW];

  sfifo_lvl_dpram #(
    .Depth (Depth),
    .Width (Width),
    .AW    (AW)
  ) u_ram (
    .clk    (clk),
    .rst    (reset),
    .WrEn   (wr_acc_s),
    .WrAddr (wr_ptr_q[AW-1:0]),
    .WrData (WRData),
    .RdEn   (rd_acc_s),
    .RdAddr (rd_ptr_q[AW-1:0]),
    .RdData (RDData)
  );

  assign RDValid     = rd_valid_q;
  assign FIFOFull    = full_s;
  assign FIFOEmpty   = empty_s;
  assign AlmostFull  = (level_q >= AF_L);
  assign AlmostEmpty = (level_q <= AE_L);
  assign Level       = level_q;

`ifdef SFIFO_LVL_ERRFLAG_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // Sticky error flags: a new error in the clearing cycle wins over ErrClr.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (FIFOWrReq & full_s) begin
      ovf_d = 1'b1;
    end else if (ErrClr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (FIFORdReq & empty_s) begin
      udf_d = 1'b1;
    end else if (ErrClr) begin
      udf_d = 1'b0;
    end else begin
      udf_d = udf_q;
    end
  end

  // Error flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign Overflow  = ovf_q;
  assign Underflow = udf_q;
`else
  logic unused_errclr_s;
  assign unused_errclr_s = ErrClr;
  assign Overflow        = 1'b0;
  assign Underflow       = 1'b0;
`endif

endmodule

// File: tb/tb_sfifo_lvl.sv
// Scoreboard bench for sfifo_lvl (Depth=8, AFThresh=6, AEThresh=2); the driver
// queues expected read data, an independent monitor checks every RDValid strobe.
module tb_sfifo_lvl;

`ifdef SFIFO_LVL_ERRFLAG_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] WRData = 8'h00;
  logic       FIFOWrReq = 1'b0;
  logic       FIFORdReq = 1'b0;
  logic       ErrClr = 1'b0;
  logic [7:0] RDData;
  logic       RDValid, FIFOFull, FIFOEmpty, AlmostFull, AlmostEmpty;
  logic [3:0] Level;
  logic       Overflow, Underflow;

  int checks = 0;
  int failures = 0;

  logic [7:0] mdl_q[$];
  logic [7:0] sb_q[$];
  bit         exp_rv = 1'b0;

  sfifo_lvl #(.Depth(8), .Width(8), .AFThresh(6), .AEThresh(2)) dut (
    .clk(clk), .reset(reset), .WRData(WRData), .FIFOWrReq(FIFOWrReq),
    .FIFORdReq(FIFORdReq), .ErrClr(ErrClr), .RDData(RDData), .RDValid(RDValid),
    .FIFOFull(FIFOFull), .FIFOEmpty(FIFOEmpty), .AlmostFull(AlmostFull),
    .AlmostEmpty(AlmostEmpty), .Level(Level), .Overflow(Overflow), .Underflow(Underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the bench's own queue decides acceptance.
  task automatic step(input bit wr, input bit rd, input logic [7:0] d, input bit clr);
    bit full_m, empty_m;
    @(negedge clk);
    FIFOWrReq = wr; FIFORdReq = rd; WRData = d; ErrClr = clr;
    @(posedge clk);
    if (reset) begin
      exp_rv = 1'b0;
    end else begin
      full_m  = (mdl_q.size() == 8);
      empty_m = (mdl_q.size() == 0);
      exp_rv  = rd && !empty_m;
      if (rd && !empty_m) sb_q.push_back(mdl_q.pop_front());
      if (wr && !full_m) mdl_q.push_back(d);
    end
    #2;
    FIFOWrReq = 1'b0; FIFORdReq = 1'b0; ErrClr = 1'b0;
  endtask

  // Monitor: RDValid must match the expected strobe; each strobe pops one word.
  always @(posedge clk) begin
    logic [7:0] e;
    #1;
    checks++;
    if (RDValid !== exp_rv) begin
      failures++;
      $display("FAIL rdvalid: got %b expected %b at %0t", RDValid, exp_rv, $time);
    end
    if (RDValid === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL rddata: got %h with no expected word at %0t", RDData, $time);
      end else begin
        e = sb_q.pop_front();
        if (RDData !== e) begin
          failures++;
          $display("FAIL rddata: got %h expected %h at %0t", RDData, e, $time);
        end
      end
    end
  end

  initial begin
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'hEE, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_level", {4'h0, Level}, 8'd0);
    chk("rst_empty", {7'd0, FIFOEmpty}, 8'd1);
    chk("rst_full", {7'd0, FIFOFull}, 8'd0);
    chk("rst_ae", {7'd0, AlmostEmpty}, 8'd1);
    chk("rst_af", {7'd0, AlmostFull}, 8'd0);
    chk("rst_rdata", RDData, 8'h00);
    chk("rst_ovf", {7'd0, Overflow}, 8'd0);
    chk("rst_udf", {7'd0, Underflow}, 8'd0);

    // Basic write then read.
    step(1'b1, 1'b0, 8'h11, 1'b0);
    step(1'b1, 1'b0, 8'h22, 1'b0);
    step(1'b1, 1'b0, 8'h33, 1'b0);
    chk("basic_level3", {4'h0, Level}, 8'd3);
    chk("basic_notempty", {7'd0, FIFOEmpty}, 8'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("basic_level0", {4'h0, Level}, 8'd0);

    // Fill to full with threshold flags.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 8'h40 + 8'(i), 1'b0);
      chk("fill_level", {4'h0, Level}, 8'(i + 1));
      chk("fill_ae", {7'd0, AlmostEmpty}, {7'd0, (i + 1) <= 2});
      chk("fill_af", {7'd0, AlmostFull}, {7'd0, (i + 1) >= 6});
      chk("fill_full", {7'd0, FIFOFull}, {7'd0, i == 7});
    end
    step(1'b1, 1'b0, 8'hFF, 1'b0);
    chk("ovr_level", {4'h0, Level}, 8'd8);
    chk("ovr_flag", {7'd0, Overflow}, {7'd0, ERR_EN});

    // Drain to 4, then 20 cycles of simultaneous read/write with wrapping pointers.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("mid_level4", {4'h0, Level}, 8'd4);
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b1, 8'h80 + 8'(k), 1'b0);
      chk("rw_level", {4'h0, Level}, 8'd4);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("drain_empty", {7'd0, FIFOEmpty}, 8'd1);

    // Read and write together on an empty FIFO: only the write lands.
    step(1'b1, 1'b1, 8'hA5, 1'b0);
    chk("ewr_level", {4'h0, Level}, 8'd1);
    chk("ewr_udf", {7'd0, Underflow}, {7'd0, ERR_EN});
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("ewr_level0", {4'h0, Level}, 8'd0);

    // Sticky error flag clear / set priority.
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("clr_ovf", {7'd0, Overflow}, 8'd0);
    chk("clr_udf", {7'd0, Underflow}, 8'd0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("udf_set", {7'd0, Underflow}, {7'd0, ERR_EN});
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("udf_hold", {7'd0, Underflow}, {7'd0, ERR_EN});
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("udf_clr", {7'd0, Underflow}, 8'd0);
    step(1'b0, 1'b1, 8'h00, 1'b1);
    chk("udf_setwins", {7'd0, Underflow}, {7'd0, ERR_EN});

    // Asynchronous reset in the middle of a burst at Level=5.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h70 + 8'(i), 1'b0);
    step(1'b1, 1'b1, 8'h75, 1'b0);
    chk("pre_rst_level", {4'h0, Level}, 8'd5);
    @(negedge clk);
    FIFOWrReq = 1'b1;
    reset = 1'b1;
    exp_rv = 1'b0;
    mdl_q.delete();
    #1;
    chk("arst_level", {4'h0, Level}, 8'd0);
    chk("arst_empty", {7'd0, FIFOEmpty}, 8'd1);
    chk("arst_rdvalid", {7'd0, RDValid}, 8'd0);
    step(1'b1, 1'b1, 8'h55, 1'b0);
    chk("rst_hold_level", {4'h0, Level}, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("arst_udf", {7'd0, Underflow}, 8'd0);
    step(1'b1, 1'b0, 8'h99, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("post_level", {4'h0, Level}, 8'd0);
    chk("sb_drained", 8'(sb_q.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
